b14_mem_responder: RTL

Memory-side responder for the b14 processor bus (addr/datao/rd/wr out of the CPU, datai into it). It holds a word-addressed 31-bit RAM window, returns read data combinationally on datai, and performs level-qualified writes. Also provided:
- a clear-on-reset sequencer;
- a testbench/boot preload port with valid/ready handshake;
- saturating access counters and a sticky out-of-range error flag.

---
 rtl/b14_mem_responder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/b14_mem_responder.sv
// b14 bus memory responder: 31-bit word RAM window with combinational read,
// level-qualified CPU writes, clear-on-reset sequencer and a preload port.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   addr, datao, rd, wr   CPU bus (word address, write data, qualifiers)
//   datai                 combinational read data back to the CPU
//   ready                 high in RUN (CPU is held in reset until then)
//   load_valid/addr/data  preload request, accepted with load_ready
//   load_ready            high in RUN
//   rd_cnt, wr_cnt        saturating read-cycle / CPU-write counters
//   collide               sticky: CPU write lost to a same-cycle preload
//   err                   sticky: rd/wr with an out-of-window address
module b14_mem_responder #(
  parameter int DEPTH_LOG2     = 8,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [19:0]           addr,
  input  logic [30:0]           datao,
  input  logic                  rd,
  input  logic                  wr,
  output logic [30:0]           datai,
  output logic                  ready,
  input  logic                  load_valid,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [30:0]           load_data,
  output logic                  load_ready,
  output logic [CNT_W-1:0]      rd_cnt,
  output logic [CNT_W-1:0]      wr_cnt,
  output logic                  collide,
  output logic                  err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t                state;
  logic [DEPTH_LOG2-1:0] clr_ptr;
  logic [30:0]           mem [DEPTH];

  logic                  active;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  cpu_ok;
  logic                  cpu_go;
  logic                  load_go;
  logic                  clr_go;
  logic                  bad;

  logic                  we;
  logic [DEPTH_LOG2-1:0] waddr;
  logic [30:0]           wdata;

  // A reset cycle blocks every access even if the state is still RUN.
  assign active   = (state == RUN) && !reset;
  assign in_range = (addr[19:DEPTH_LOG2] == '0);
  assign idx      = addr[DEPTH_LOG2-1:0];

  assign cpu_ok  = active && wr && in_range;
  assign load_go = active && load_valid;
  assign cpu_go  = cpu_ok && !load_valid;
  assign clr_go  = (state == CLEAR) && !reset && CLEAR_ON_RESET;
  assign bad     = active && (rd || wr) && !in_range;

  assign ready      = active;
  assign load_ready = active;
  assign datai      = (active && in_range) ? mem[idx] : '0;

  // Single write port: clear, then preload, then CPU.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    unique case (1'b1)
      clr_go: begin
        we    = 1'b1;
        waddr = clr_ptr;
      end
      load_go: begin
        we    = 1'b1;
        waddr = load_addr;
        wdata = load_data;
      end
      cpu_go: begin
        we    = 1'b1;
        waddr = idx;
        wdata = datao;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      collide <= 1'b0;
      err     <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (!CLEAR_ON_RESET || clr_ptr == '1) state <= RUN;
        end
        RUN: begin
          if (rd && in_range && rd_cnt != '1)
            rd_cnt <= rd_cnt + 1'b1;
          if (cpu_go && wr_cnt != '1)
            wr_cnt <= wr_cnt + 1'b1;
          if (cpu_ok && load_valid)
            collide <= 1'b1;
          if (bad)
            err <= 1'b1;
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule
